// File: rtl/lcb_mem_arbiter.sv
// Round-robin arbiter granting one of four requesters atomic read-modify-write
// access to a shared memory port, with per-grant timeout and buffer-switch abort.
module lcb_mem_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        swch,
  input  logic [3:0]  req,
  input  logic [47:0] wrd_out_bus,
  input  logic [39:0] wrd_addr_bus,
  input  logic [39:0] old_addr_bus,
  input  logic [3:0]  wren_bus,
  input  logic [3:0]  old_rden_bus,
  input  logic [11:0] comm_old_wrd,
  output logic [11:0] comm_wrd_out,
  output logic [9:0]  comm_wrd_addr,
  output logic        comm_wren,
  output logic [9:0]  comm_old_wrd_addr,
  output logic        comm_old_rd_en,
  output logic [11:0] old_wrd,
  output logic [3:0]  gnt,
  output logic [1:0]  active_id,
  output logic        busy,
  output logic        timeout_err,
  output logic        abort_err
);

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 2;
  localparam int unsigned DW    = 12;
  localparam int unsigned AW    = 10;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   active_id_q, active_id_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  lockout_q, lockout_d;
  logic             abort_q, abort_d;
  logic             swch_q;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;
  logic             abort_err_q, abort_err_d;

  logic             swch_edge;
  logic [NREQ-1:0]  eligible;
  logic             sel_valid;
  logic [IDW-1:0]   sel_id;
  logic [IDW-1:0]   cand;

  assign swch_edge = swch ^ swch_q;
  assign eligible  = req & ~lockout_q;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = last_q + IDW'(k + 1);
      if (!sel_valid && eligible[cand]) begin
        sel_valid = 1'b1;
        sel_id    = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    active_id_d   = active_id_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    lockout_d     = lockout_q & req;
    abort_d       = abort_q;
    timeout_err_d = 1'b0;
    abort_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid && !swch_edge) begin
          state_d     = ST_GRANT;
          gnt_d       = NREQ'(1) << sel_id;
          active_id_d = sel_id;
          last_d      = sel_id;
          cnt_d       = '0;
        end
      end
      ST_GRANT: begin
        if (swch_edge) begin
          abort_d     = 1'b1;
          abort_err_d = 1'b1;
        end
        if (!req[active_id_q]) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d                = ST_RELEASE;
          gnt_d                  = '0;
          timeout_err_d          = 1'b1;
          lockout_d[active_id_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        abort_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      active_id_q   <= '0;
      last_q        <= IDW'(NREQ - 1);
      cnt_q         <= '0;
      lockout_q     <= '0;
      abort_q       <= 1'b0;
      swch_q        <= swch;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      abort_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      active_id_q   <= active_id_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      lockout_q     <= lockout_d;
      abort_q       <= abort_d;
      swch_q        <= swch;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      abort_err_q   <= abort_err_d;
    end
  end

  // Shared port follows the active requester only while granted
  always_comb begin
    comm_wrd_out      = '0;
    comm_wrd_addr     = '0;
    comm_wren         = 1'b0;
    comm_old_wrd_addr = '0;
    comm_old_rd_en    = 1'b0;
    if (state_q == ST_GRANT) begin
      for (int i = 0; i < NREQ; i++) begin
        if (active_id_q == IDW'(i)) begin
          comm_wrd_out      = wrd_out_bus[DW*i +: DW];
          comm_wrd_addr     = wrd_addr_bus[AW*i +: AW];
          comm_old_wrd_addr = old_addr_bus[AW*i +: AW];
          comm_old_rd_en    = old_rden_bus[i];
          comm_wren         = wren_bus[i] & ~abort_q & ~swch_edge;
        end
      end
    end
  end

  assign old_wrd     = comm_old_wrd;
  assign gnt         = gnt_q;
  assign active_id   = active_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign abort_err   = abort_err_q;

endmodule

// File: tb/tb_lcb_mem_arbiter.sv
// Bench for lcb_mem_arbiter: vector table plus round-robin and timeout
// sequences, each step checked through an expectation queue.
module tb_lcb_mem_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        swch;
  logic [3:0]  req;
  logic [47:0] wrd_out_bus;
  logic [39:0] wrd_addr_bus;
  logic [39:0] old_addr_bus;
  logic [3:0]  wren_bus;
  logic [3:0]  old_rden_bus;
  logic [11:0] comm_old_wrd;
  logic [11:0] comm_wrd_out;
  logic [9:0]  comm_wrd_addr;
  logic        comm_wren;
  logic [9:0]  comm_old_wrd_addr;
  logic        comm_old_rd_en;
  logic [11:0] old_wrd;
  logic [3:0]  gnt;
  logic [1:0]  active_id;
  logic        busy;
  logic        timeout_err;
  logic        abort_err;

  lcb_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk              (clk),
    .reset            (reset),
    .swch             (swch),
    .req              (req),
    .wrd_out_bus      (wrd_out_bus),
    .wrd_addr_bus     (wrd_addr_bus),
    .old_addr_bus     (old_addr_bus),
    .wren_bus         (wren_bus),
    .old_rden_bus     (old_rden_bus),
    .comm_old_wrd     (comm_old_wrd),
    .comm_wrd_out     (comm_wrd_out),
    .comm_wrd_addr    (comm_wrd_addr),
    .comm_wren        (comm_wren),
    .comm_old_wrd_addr(comm_old_wrd_addr),
    .comm_old_rd_en   (comm_old_rd_en),
    .old_wrd          (old_wrd),
    .gnt              (gnt),
    .active_id        (active_id),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .abort_err        (abort_err)
  );

  always #5 clk = ~clk;

  // Inputs applied before an edge and the outputs required right after it
  typedef struct {
    logic       rst;
    logic       sw;
    logic [3:0] req;
    logic [3:0] wren;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       terr;
    logic       aerr;
    logic       cw;
  } vec_t;

  vec_t        tbl[$];
  vec_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          step_no = 0;
  logic [3:0]  rden_pat = 4'b1010;
  logic [11:0] ow_exp;
  int          order[5] = '{0, 1, 2, 3, 0};

  function automatic vec_t mk(int rst, int sw, int rq, int wr, int g, int id,
                              int b, int t, int a, int cw);
    vec_t v;
    v.rst = 1'(rst);  v.sw = 1'(sw);   v.req = 4'(rq); v.wren = 4'(wr);
    v.gnt = 4'(g);    v.id = 2'(id);   v.busy = 1'(b); v.terr = 1'(t);
    v.aerr = 1'(a);   v.cw = 1'(cw);
    return v;
  endfunction

  function automatic int onehot(int e);
    return 1 << e;
  endfunction

  task automatic step(input vec_t v);
    vec_t        e;
    logic [11:0] ewd;
    logic [9:0]  ewa, eoa;
    logic        eren, ew;
    reset        = v.rst;
    swch         = v.sw;
    req          = v.req;
    wren_bus     = v.wren;
    ow_exp       = 12'($urandom);
    comm_old_wrd = ow_exp;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    step_no++;
    ewd = '0; ewa = '0; eoa = '0; eren = 1'b0; ew = 1'b0;
    if (e.gnt != 4'b0000) begin
      ewd  = 12'hA00 + 12'(e.id);
      ewa  = 10'h100 + 10'(e.id);
      eoa  = 10'h200 + 10'(e.id);
      eren = rden_pat[e.id];
      ew   = e.cw;
    end
    total++;
    if ({gnt, active_id} !== {e.gnt, e.id}) begin
      bad++;
      $display("FAIL grant step=%0d got gnt=%b id=%0d want gnt=%b id=%0d",
               step_no, gnt, active_id, e.gnt, e.id);
    end
    total++;
    if ({busy, timeout_err, abort_err} !== {e.busy, e.terr, e.aerr}) begin
      bad++;
      $display("FAIL status step=%0d got busy/terr/aerr=%b%b%b want %b%b%b",
               step_no, busy, timeout_err, abort_err, e.busy, e.terr, e.aerr);
    end
    total++;
    if ({comm_wrd_out, comm_wrd_addr, comm_old_wrd_addr, comm_old_rd_en, comm_wren}
        !== {ewd, ewa, eoa, eren, ew}) begin
      bad++;
      $display("FAIL comm step=%0d got wd=%h wa=%h oa=%h ren=%b wren=%b want wd=%h wa=%h oa=%h ren=%b wren=%b",
               step_no, comm_wrd_out, comm_wrd_addr, comm_old_wrd_addr, comm_old_rd_en,
               comm_wren, ewd, ewa, eoa, eren, ew);
    end
    total++;
    if (old_wrd !== ow_exp) begin
      bad++;
      $display("FAIL old_wrd step=%0d got %h want %h", step_no, old_wrd, ow_exp);
    end
  endtask

  initial begin
    reset = 1'b1; swch = 1'b0; req = '0; wren_bus = '0; comm_old_wrd = '0;
    old_rden_bus = rden_pat;
    for (int i = 0; i < 4; i++) begin
      wrd_out_bus[12*i +: 12] = 12'hA00 + 12'(i);
      wrd_addr_bus[10*i +: 10] = 10'h100 + 10'(i);
      old_addr_bus[10*i +: 10] = 10'h200 + 10'(i);
    end

    // rst, swch, req, wren -> gnt, id, busy, terr, aerr, comm_wren
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0001, 4'b0000, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0, 0, 0));
    // buffer switch on the second grant cycle of requester 1
    tbl.push_back(mk(0, 0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 4'b0010, 4'b0000, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'b0000, 4'b0010, 4'b0000, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0, 0, 0));
    // switch edge while idle holds off the grant by one cycle
    tbl.push_back(mk(0, 0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 0, 0, 1));
    // reset in the middle of a grant
    tbl.push_back(mk(1, 0, 4'b1100, 4'b1111, 4'b0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b1100, 4'b1111, 4'b0100, 2, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b1111, 4'b0000, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b1111, 4'b0000, 2, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // all four requesting: order 0,1,2,3,0 with a release gap each time
    step(mk(1, 0, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++)
        step(mk(0, 0, 4'b1111, 4'b1111, onehot(order[k]), order[k], 1, 0, 0, 1));
      step(mk(0, 0, 4'b1111 & ~onehot(order[k]), 4'b1111, 4'b0000, order[k], 1, 0, 0, 0));
      step(mk(0, 0, 4'b1111, 4'b1111, 4'b0000, order[k], 0, 0, 0, 0));
    end

    // requester 2 stuck high: timeout after TO cycles, then lockout
    step(mk(1, 0, 4'b0000, 4'b0100, 4'b0000, 0, 0, 0, 0, 0));
    for (int c = 0; c < int'(TO); c++)
      step(mk(0, 0, 4'b0100, 4'b0100, 4'b0100, 2, 1, 0, 0, 1));
    step(mk(0, 0, 4'b0100, 4'b0100, 4'b0000, 2, 1, 1, 0, 0));
    step(mk(0, 0, 4'b0100, 4'b0100, 4'b0000, 2, 0, 0, 0, 0));
    step(mk(0, 0, 4'b0100, 4'b0100, 4'b0000, 2, 0, 0, 0, 0));
    step(mk(0, 0, 4'b0110, 4'b0100, 4'b0010, 1, 1, 0, 0, 0));
    step(mk(0, 0, 4'b0100, 4'b0100, 4'b0000, 1, 1, 0, 0, 0));
    step(mk(0, 0, 4'b0100, 4'b0100, 4'b0000, 1, 0, 0, 0, 0));
    step(mk(0, 0, 4'b0100, 4'b0100, 4'b0000, 1, 0, 0, 0, 0));
    step(mk(0, 0, 4'b0000, 4'b0100, 4'b0000, 1, 0, 0, 0, 0));
    step(mk(0, 0, 4'b0100, 4'b0100, 4'b0100, 2, 1, 0, 0, 1));
    step(mk(0, 0, 4'b0000, 4'b0100, 4'b0000, 2, 1, 0, 0, 0));
    step(mk(0, 0, 4'b0000, 4'b0100, 4'b0000, 2, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcb_mem_arbiter.md
LCB_MEM_ARBITER -- requirements
Module: lcb_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum GRANT cycles per transaction (range 4..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock (80 MHz domain); all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port swch, input, 1 bit: ping-pong buffer select from the frame former.
REQ-005 SHALL have port req, input, 4 bits: per-requester request for one atomic read-modify-write transaction.
REQ-006 SHALL have ports wrd_out_bus (48), wrd_addr_bus (40), old_addr_bus (40), all inputs: packed per-requester write data, write address and read address; requester i occupies slice [12i+11:12i] or [10i+9:10i].
REQ-007 SHALL have ports wren_bus and old_rden_bus, inputs, 4 bits each: per-requester write and read enables.
REQ-008 SHALL have port comm_old_wrd, input, 12 bits: read data from the shared memory port.
REQ-009 SHALL have ports comm_wrd_out (12), comm_wrd_addr (10), comm_wren (1), comm_old_wrd_addr (10), comm_old_rd_en (1), all outputs: the shared memory port.
REQ-010 SHALL have port old_wrd, output, 12 bits: comm_old_wrd passed through to all requesters.
REQ-011 SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-012 SHALL have ports active_id (2 bits), busy (1 bit), timeout_err (1 bit) and abort_err (1 bit), all outputs.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT and RELEASE.
REQ-014 IDLE -> GRANT SHALL occur when any eligible req bit is high and no swch edge is present this cycle; gnt and active_id SHALL be valid on the next cycle.
REQ-015 Selection SHALL be round-robin: search begins at (last_granted+1) mod 4; last_granted resets to 3, so requester 0 wins first.
REQ-016 GRANT -> RELEASE SHALL occur when req[active_id] falls; gnt SHALL drop in the same registered update.
REQ-017 RELEASE SHALL last exactly 1 cycle with gnt=0 and then return to IDLE, giving a guaranteed idle gap between transactions.
REQ-018 In GRANT, comm_* SHALL be a combinational mux of requester active_id's slices; outside GRANT all comm_* outputs SHALL be 0.
REQ-019 A GRANT cycle counter SHALL be cleared on entry to GRANT; when it reaches TIMEOUT-1 with req still high:
- transition to RELEASE;
- pulse timeout_err for 1 cycle;
- set lockout[active_id].
REQ-020 A locked-out requester SHALL be ineligible until its req is seen low, which clears its lockout bit.
REQ-021 swch SHALL be registered (swch_d); an edge is defined as swch^swch_d.
REQ-022 An edge during GRANT SHALL:
- pulse abort_err for 1 cycle;
- set the abort flag;
- force comm_wren to 0 for the rest of that grant.
The grant itself is held until req falls or timeout. The abort flag clears in RELEASE.
REQ-023 An edge during IDLE SHALL block a new grant for that cycle only.
REQ-024 busy SHALL be 1 whenever the state is not IDLE.
REQ-025 old_wrd SHALL equal comm_old_wrd, unregistered, in all states.

Reset
REQ-026 While reset=1 the following SHALL be forced at the next edge:
- state=IDLE, gnt=0, active_id=0, last_granted=3;
- counter=0, lockout=0, abort flag=0, swch_d=swch;
- timeout_err=0, abort_err=0, busy=0.
REQ-027 Reset mid-GRANT SHALL drop gnt and comm_wren on the next cycle, with no RELEASE cycle.

Verification
REQ-028 req=4'b0001 held 5 cycles, then dropped -> gnt=0001 one cycle after req rises; comm_* follow slice 0; gnt=0 one cycle after the drop; busy low 2 cycles after the drop.
REQ-029 req=4'b1111 held permanently with each requester dropping after 3 GRANT cycles -> grant order 0,1,2,3,0, with one RELEASE gap between grants.
REQ-030 req[2] stuck high, TIMEOUT=8 -> gnt[2] for exactly 8 cycles, timeout_err one pulse, requester 2 not regranted until req[2] toggles low.
REQ-031 swch toggles on the 2nd GRANT cycle while wren_bus[1]=1 -> abort_err one pulse, comm_wren=0 for the remainder of the grant, gnt[1] held until req[1] falls.
REQ-032 reset asserted in the middle of GRANT -> gnt=0, comm_wren=0 next cycle; after release, first grant goes to the lowest active req.
